next_pc_sequencer: RTL and testbench

Next-address stage that sits directly upstream of the program counter: it drives the counter's IADDR and WO inputs and reads back its OADDR as the current address. Each cycle it selects the next instruction address from sequential increment, jump, conditional branch, call or return, and it handles stall, halt/resume and boot sequencing. An optional hardware return-address stack supports CALL/RET.

---
 rtl/next_pc_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_next_pc_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_sequencer.sv
// Next-address stage feeding the program counter: picks sequential, branch, jump, call or return
// targets and sequences boot, halt and fault. Optional return stack enabled by `define RETURN_STACK_EN.
module next_pc_sequencer #(
    parameter int                    ADDR_WIDTH  = 11,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = {ADDR_WIDTH{1'b0}},
    parameter int                    STACK_DEPTH = 4
) (
    input  logic                  WCLOCK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] CADDR,
    input  logic                  STALL,
    input  logic                  BRANCH,
    input  logic                  BTAKEN,
    input  logic                  JUMP,
    input  logic                  CALL,
    input  logic                  RET,
    input  logic [ADDR_WIDTH-1:0] BTARGET,
    input  logic                  HALT,
    input  logic                  RESUME,
    output logic [ADDR_WIDTH-1:0] NADDR,
    output logic                  WO,
    output logic [1:0]            STATE,
    output logic                  SOVF,
    output logic                  SUNF
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1'b1);

    // A depth below two leaves no room for a nested call and is rejected at elaboration.
    if (STACK_DEPTH < 2) begin : g_bad_depth
        $error("STACK_DEPTH must be at least 2");
    end

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   naddr_r, naddr_s;
    logic                    wo_r, wo_s;
    logic                    sovf_r, sovf_s;
    logic                    sunf_r, sunf_s;
    logic [ADDR_WIDTH-1:0]   incr_s;

    assign incr_s = CADDR + ADDR_ONE;

`ifdef RETURN_STACK_EN
    localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PW:0]   SP_FULL = (PW + 1)'(STACK_DEPTH);
    localparam logic [PW-1:0] IDX_ONE = PW'(1'b1);

    logic [ADDR_WIDTH-1:0] stack_r [STACK_DEPTH];
    logic [PW:0]           sp_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  stack_full_s;
    logic                  stack_empty_s;
    logic [PW-1:0]         top_idx_s;
    logic [ADDR_WIDTH-1:0] stack_top_s;

    // sp_r counts entries, so the top lives one below it; the low bits wrap correctly when full.
    assign stack_full_s  = (sp_r == SP_FULL);
    assign stack_empty_s = (sp_r == {(PW + 1){1'b0}});
    assign top_idx_s     = sp_r[PW-1:0] - IDX_ONE;
    assign stack_top_s   = stack_r[top_idx_s];

    // Return stack storage and pointer update on push or pop.
    always_ff @(posedge WCLOCK or posedge RESET) begin
        if (RESET) begin
            sp_r <= {(PW + 1){1'b0}};
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= {ADDR_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            stack_r[sp_r[PW-1:0]] <= incr_s;
            sp_r                  <= sp_r + (PW + 1)'(1'b1);
        end else if (pop_s) begin
            sp_r <= sp_r - (PW + 1)'(1'b1);
        end else begin
            sp_r <= sp_r;
        end
    end
`endif

    // Next-state and next-output selection by fixed control priority.
    always_comb begin
        naddr_s = naddr_r;
        wo_s    = 1'b0;
        state_s = state_r;
        sovf_s  = sovf_r;
        sunf_s  = sunf_r;
`ifdef RETURN_STACK_EN
        push_s  = 1'b0;
        pop_s   = 1'b0;
`endif
        case (state_r)
            ST_BOOT: begin
                naddr_s = RESET_ADDR;
                wo_s    = 1'b1;
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (STALL) begin
                    wo_s = 1'b0;
                end else if (HALT) begin
                    state_s = ST_HOLD;
                end else if (RET) begin
`ifdef RETURN_STACK_EN
                    if (stack_empty_s) begin
                        sunf_s  = 1'b1;
                        state_s = ST_FAULT;
                    end else begin
                        pop_s   = 1'b1;
                        naddr_s = stack_top_s;
                        wo_s    = 1'b1;
                    end
`else
                    naddr_s = incr_s;
                    wo_s    = 1'b1;
`endif
                end else if (CALL) begin
`ifdef RETURN_STACK_EN
                    if (stack_full_s) begin
                        sovf_s  = 1'b1;
                        state_s = ST_FAULT;
                    end else begin
                        push_s  = 1'b1;
                        naddr_s = BTARGET;
                        wo_s    = 1'b1;
                    end
`else
                    naddr_s = BTARGET;
                    wo_s    = 1'b1;
`endif
                end else if (JUMP || (BRANCH && BTAKEN)) begin
                    naddr_s = BTARGET;
                    wo_s    = 1'b1;
                end else begin
                    naddr_s = incr_s;
                    wo_s    = 1'b1;
                end
            end
            ST_HOLD: begin
                if (RESUME) begin
                    naddr_s = incr_s;
                    wo_s    = 1'b1;
                    state_s = ST_RUN;
                end else begin
                    wo_s = 1'b0;
                end
            end
            ST_FAULT: begin
                wo_s = 1'b0;
            end
            default: begin
                wo_s    = 1'b0;
                state_s = ST_FAULT;
            end
        endcase
    end

    // Registered outputs and FSM state.
    always_ff @(posedge WCLOCK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_BOOT;
            naddr_r <= RESET_ADDR;
            wo_r    <= 1'b0;
            sovf_r  <= 1'b0;
            sunf_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            naddr_r <= naddr_s;
            wo_r    <= wo_s;
            sovf_r  <= sovf_s;
            sunf_r  <= sunf_s;
        end
    end

    assign NADDR = naddr_r;
    assign WO    = wo_r;
    assign STATE = state_r;
    assign SOVF  = sovf_r;
    assign SUNF  = sunf_r;

endmodule

// File: tb/tb_next_pc_sequencer.sv
// Bench for next_pc_sequencer: directed scenarios plus randomized traffic against a
// behavioural model; the return-stack scenarios follow `define RETURN_STACK_EN.
module tb_next_pc_sequencer;

    localparam int          AW = 11;
    localparam logic [10:0] RA = 11'h010;
    localparam int          SD = 4;

    logic        WCLOCK = 1'b0;
    logic        RESET  = 1'b1;
    logic [10:0] CADDR  = 11'h000;
    logic [10:0] BTARGET = 11'h000;
    logic        STALL = 1'b0, BRANCH = 1'b0, BTAKEN = 1'b0, JUMP = 1'b0;
    logic        CALL = 1'b0, RET = 1'b0, HALT = 1'b0, RESUME = 1'b0;
    logic [10:0] NADDR;
    logic        WO, SOVF, SUNF;
    logic [1:0]  STATE;

    int checks = 0;
    int errors = 0;

    // behavioural model
    logic [1:0]  m_state;
    logic [10:0] m_naddr;
    logic        m_wo, m_sovf, m_sunf;
    logic [10:0] m_stack[$];
    logic [10:0] pc;
    logic [15:0] obs, exp;

    assign obs = {NADDR, WO, STATE, SOVF, SUNF};

    next_pc_sequencer #(.ADDR_WIDTH(AW), .RESET_ADDR(RA), .STACK_DEPTH(SD)) dut (
        .WCLOCK(WCLOCK), .RESET(RESET), .CADDR(CADDR), .STALL(STALL), .BRANCH(BRANCH),
        .BTAKEN(BTAKEN), .JUMP(JUMP), .CALL(CALL), .RET(RET), .BTARGET(BTARGET),
        .HALT(HALT), .RESUME(RESUME), .NADDR(NADDR), .WO(WO), .STATE(STATE),
        .SOVF(SOVF), .SUNF(SUNF)
    );

    always #5 WCLOCK = ~WCLOCK;

    task automatic clear_inputs();
        STALL = 1'b0; BRANCH = 1'b0; BTAKEN = 1'b0; JUMP = 1'b0;
        CALL = 1'b0; RET = 1'b0; HALT = 1'b0; RESUME = 1'b0;
    endtask

    task automatic model_reset();
        m_state = 2'd0; m_naddr = RA; m_wo = 1'b0; m_sovf = 1'b0; m_sunf = 1'b0;
        m_stack.delete();
        exp = {m_naddr, m_wo, m_state, m_sovf, m_sunf};
    endtask

    // One clock of the reference behaviour, from the sampled inputs.
    task automatic model_step();
        logic [10:0] inc;
        inc = CADDR + 11'd1;
        m_wo = 1'b0;
        case (m_state)
            2'd0: begin m_naddr = RA; m_wo = 1'b1; m_state = 2'd1; end
            2'd1: begin
                if (STALL) begin
                end else if (HALT) begin
                    m_state = 2'd2;
                end else if (RET) begin
`ifdef RETURN_STACK_EN
                    if (m_stack.size() == 0) begin m_sunf = 1'b1; m_state = 2'd3; end
                    else begin m_naddr = m_stack.pop_back(); m_wo = 1'b1; end
`else
                    m_naddr = inc; m_wo = 1'b1;
`endif
                end else if (CALL) begin
`ifdef RETURN_STACK_EN
                    if (m_stack.size() == SD) begin m_sovf = 1'b1; m_state = 2'd3; end
                    else begin m_stack.push_back(inc); m_naddr = BTARGET; m_wo = 1'b1; end
`else
                    m_naddr = BTARGET; m_wo = 1'b1;
`endif
                end else if (JUMP || (BRANCH && BTAKEN)) begin
                    m_naddr = BTARGET; m_wo = 1'b1;
                end else begin
                    m_naddr = inc; m_wo = 1'b1;
                end
            end
            2'd2: if (RESUME) begin m_naddr = inc; m_wo = 1'b1; m_state = 2'd1; end
            default: ;
        endcase
        exp = {m_naddr, m_wo, m_state, m_sovf, m_sunf};
    endtask

    task automatic tick();
        @(posedge WCLOCK);
        model_step();
        #1;
        if (m_wo) pc = m_naddr;
    endtask

    task automatic do_reset();
        @(negedge WCLOCK);
        RESET = 1'b1;
        clear_inputs();
        model_reset();
        #2;
        RESET = 1'b0;
        tick();  // boot cycle
    endtask

    task automatic test_reset();
        clear_inputs();
        model_reset();
        #12;
        checks++;
        if (obs !== exp || obs !== {RA, 1'b0, 2'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_values: got %h expected %h", obs, exp);
        end
        @(negedge WCLOCK);
        RESET = 1'b0;
        CADDR = 11'h000;
        tick();
        checks++;
        if (obs !== exp || NADDR !== 11'h010 || WO !== 1'b1 || STATE !== 2'd1) begin
            errors++; $display("FAIL boot: got %h expected %h", obs, exp);
        end
        for (int i = 1; i <= 2; i++) begin
            CADDR = NADDR;
            tick();
            checks++;
            if (obs !== exp || NADDR !== 11'(11'h010 + i) || WO !== 1'b1) begin
                errors++; $display("FAIL free_run%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_wrap_stall();
        clear_inputs();
        CADDR = 11'h7FF;
        tick();
        checks++;
        if (obs !== exp || NADDR !== 11'h000 || WO !== 1'b1) begin
            errors++; $display("FAIL wrap: got %h expected %h", obs, exp);
        end
        CADDR = 11'h000;
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== exp || WO !== 1'b0 || NADDR !== 11'h000) begin
                errors++; $display("FAIL stall%0d: got %h expected %h", i, obs, exp);
            end
        end
        STALL = 1'b0;
        tick();
        checks++;
        if (obs !== exp || NADDR !== 11'h001 || WO !== 1'b1) begin
            errors++; $display("FAIL stall_release: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_branch();
        clear_inputs();
        CADDR = 11'h020; BRANCH = 1'b1; BTAKEN = 1'b0; BTARGET = 11'h100;
        tick();
        checks++;
        if (obs !== exp || NADDR !== 11'h021) begin
            errors++; $display("FAIL branch_not_taken: got %h expected %h", obs, exp);
        end
        BTAKEN = 1'b1;
        tick();
        checks++;
        if (obs !== exp || NADDR !== 11'h100) begin
            errors++; $display("FAIL branch_taken: got %h expected %h", obs, exp);
        end
        BTAKEN = 1'b0; JUMP = 1'b1; BTARGET = 11'h155;
        tick();
        checks++;
        if (obs !== exp || NADDR !== 11'h155 || WO !== 1'b1) begin
            errors++; $display("FAIL jump_over_branch: got %h expected %h", obs, exp);
        end
        STALL = 1'b1; BTARGET = 11'h3AA;
        tick();
        checks++;
        if (obs !== exp || WO !== 1'b0 || NADDR !== 11'h155) begin
            errors++; $display("FAIL stall_over_jump: got %h expected %h", obs, exp);
        end
        clear_inputs();
    endtask

    task automatic test_call_ret();
        logic [10:0] want [6];
`ifdef RETURN_STACK_EN
        want = '{11'h200, 11'h300, 11'h206, 11'h031, 11'h400, 11'h051};
`else
        want = '{11'h200, 11'h300, 11'h301, 11'h207, 11'h400, 11'h401};
`endif
        clear_inputs();
        CADDR = 11'h030; CALL = 1'b1; BTARGET = 11'h200; tick();
        checks++;
        if (obs !== exp || NADDR !== want[0]) begin errors++; $display("FAIL call1: got %h expected %h", obs, exp); end
        CADDR = 11'h205; BTARGET = 11'h300; tick();
        checks++;
        if (obs !== exp || NADDR !== want[1]) begin errors++; $display("FAIL call2: got %h expected %h", obs, exp); end
        CALL = 1'b0; RET = 1'b1; CADDR = 11'h300; tick();
        checks++;
        if (obs !== exp || NADDR !== want[2]) begin errors++; $display("FAIL ret1: got %h expected %h", obs, exp); end
        CADDR = 11'h206; tick();
        checks++;
        if (obs !== exp || NADDR !== want[3]) begin errors++; $display("FAIL ret2: got %h expected %h", obs, exp); end
        RET = 1'b0; CALL = 1'b1; CADDR = 11'h050; BTARGET = 11'h400; tick();
        checks++;
        if (obs !== exp || NADDR !== want[4]) begin errors++; $display("FAIL call3: got %h expected %h", obs, exp); end
        RET = 1'b1; CADDR = 11'h400; BTARGET = 11'h500; tick();
        checks++;
        if (obs !== exp || NADDR !== want[5] || WO !== 1'b1) begin
            errors++; $display("FAIL ret_beats_call: got %h expected %h", obs, exp);
        end
        clear_inputs();
    endtask

    task automatic test_faults();
        logic [1:0] want_state;
`ifdef RETURN_STACK_EN
        want_state = 2'd3;
`else
        want_state = 2'd1;
`endif
        do_reset();
        for (int i = 0; i < 5; i++) begin
            CALL = 1'b1; CADDR = 11'(11'h060 + i); BTARGET = 11'(11'h600 + 11'h010 * i);
            tick();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL call_chain%0d: got %h expected %h", i, obs, exp); end
        end
        checks++;
        if (STATE !== want_state || SOVF !== (want_state == 2'd3) || WO !== (want_state != 2'd3)) begin
            errors++; $display("FAIL overflow: got state=%0d sovf=%b wo=%b expected state=%0d", STATE, SOVF, WO, want_state);
        end
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            RESUME = 1'b1; JUMP = 1'b1; CADDR = 11'($urandom);
            tick();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL after_overflow%0d: got %h expected %h", i, obs, exp); end
        end
        do_reset();
        RET = 1'b1; CADDR = 11'h070;
        tick();
        checks++;
        if (obs !== exp || STATE !== want_state || SUNF !== (want_state == 2'd3)) begin
            errors++; $display("FAIL underflow: got %h expected %h", obs, exp);
        end
        do_reset();
    endtask

    task automatic test_halt_reset();
        clear_inputs();
        CADDR = 11'h040; HALT = 1'b1;
        tick();
        checks++;
        if (obs !== exp || STATE !== 2'd2 || WO !== 1'b0) begin
            errors++; $display("FAIL halt: got %h expected %h", obs, exp);
        end
        HALT = 1'b0; STALL = 1'b1;
        tick();
        checks++;
        if (obs !== exp || STATE !== 2'd2 || WO !== 1'b0) begin
            errors++; $display("FAIL hold_idle: got %h expected %h", obs, exp);
        end
        STALL = 1'b1; RESUME = 1'b1;
        tick();
        checks++;
        if (obs !== exp || NADDR !== 11'h041 || STATE !== 2'd1 || WO !== 1'b1) begin
            errors++; $display("FAIL resume: got %h expected %h", obs, exp);
        end
        clear_inputs();
        CADDR = 11'h041; JUMP = 1'b1; BTARGET = 11'h5A5;
        tick();
        @(negedge WCLOCK);
        #2 RESET = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs !== exp || obs !== {RA, 1'b0, 2'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_reset: got %h expected %h", obs, exp);
        end
        #1 RESET = 1'b0;
        clear_inputs();
        tick();
        checks++;
        if (obs !== exp || NADDR !== RA || WO !== 1'b1) begin
            errors++; $display("FAIL reboot: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_random();
        int fault_cycles;
        fault_cycles = 0;
        pc = NADDR;
        for (int i = 0; i < 400; i++) begin
            STALL   = ($urandom_range(0, 9) == 0);
            HALT    = ($urandom_range(0, 19) == 0);
            RESUME  = ($urandom_range(0, 2) == 0);
            RET     = ($urandom_range(0, 11) == 0);
            CALL    = ($urandom_range(0, 9) == 0);
            JUMP    = ($urandom_range(0, 11) == 0);
            BRANCH  = ($urandom_range(0, 5) == 0);
            BTAKEN  = $urandom_range(0, 1);
            BTARGET = 11'($urandom);
            CADDR   = ($urandom_range(0, 15) == 0) ? 11'h7FF : pc;
            tick();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL random%0d: got %h expected %h", i, obs, exp); end
            if (m_state == 2'd3) fault_cycles++;
            if (fault_cycles > 2) begin
                fault_cycles = 0;
                do_reset();
                pc = NADDR;
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_wrap_stall();
        test_branch();
        test_call_ret();
        test_halt_reset();
        test_faults();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
